// File: rtl/mem_line_bank.sv
// Bank of DEPTH lines, each WIDTH bits wide, with one shared write port, a registered read port and a line-by-line clear sweep.
// Optional per-line even parity with error injection is enabled by defining MEM_LINE_PARITY_EN.
module mem_line_bank #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              line_select,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read_en,
    input  logic              write_en,
    input  logic              clear_req,
`ifdef MEM_LINE_PARITY_EN
    input  logic              inject_err,
    output logic              parity_err,
`endif
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx_reg;
    logic [ADDR_W-1:0] clr_idx_next;

    logic              in_range;
    logic              wr_accept;
    logic              rd_accept;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  line_mem [DEPTH];

    assign in_range = ({1'b0, addr} < DEPTH_EXT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            IDLE: begin
                if (line_select && clear_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                end
            end
            CLEAR: begin
                if (clr_idx_reg == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_idx_next = '0;
            end
        endcase
    end

    // A clear request in the same cycle as a read or write takes priority and drops the access.
    always_comb begin
        busy      = (state_reg == CLEAR);
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        if (state_reg == IDLE && line_select && !clear_req) begin
            wr_accept = write_en && in_range;
            rd_accept = read_en;
        end
    end

    assign rd_data = in_range ? line_mem[addr] : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_accept;
            if (rd_accept) begin
                data_out <= rd_data;
            end
        end
    end

`ifdef MEM_LINE_PARITY_EN
    logic par_mem [DEPTH];
    logic rd_par_err;

    assign rd_par_err = in_range ? (par_mem[addr] ^ (^line_mem[addr])) : 1'b0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (rd_accept) begin
            parity_err <= rd_par_err;
        end
    end
`endif

    // Each line is its own register so reset can zero the whole bank in one edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
            logic [WIDTH-1:0] line_reg;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    line_reg <= '0;
                end else if (busy && clr_idx_reg == ADDR_W'(gi)) begin
                    line_reg <= '0;
                end else if (wr_accept && addr == ADDR_W'(gi)) begin
                    line_reg <= data_in;
                end
            end

            assign line_mem[gi] = line_reg;

`ifdef MEM_LINE_PARITY_EN
            logic par_reg;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    par_reg <= 1'b0;
                end else if (busy && clr_idx_reg == ADDR_W'(gi)) begin
                    par_reg <= 1'b0;
                end else if (wr_accept && addr == ADDR_W'(gi)) begin
                    par_reg <= (^data_in) ^ inject_err;
                end
            end

            assign par_mem[gi] = par_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_mem_line_bank.sv
// Directed bench for mem_line_bank (WIDTH=8, DEPTH=4): read expectations go through a scoreboard queue.
// Define MEM_LINE_PARITY_EN to also exercise the parity ports.
module tb_mem_line_bank;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              line_select;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data_in;
    logic              read_en;
    logic              write_en;
    logic              clear_req;
    logic [WIDTH-1:0]  data_out;
    logic              data_valid;
    logic              busy;
`ifdef MEM_LINE_PARITY_EN
    logic              inject_err;
    logic              parity_err;
`endif

    mem_line_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .line_select (line_select),
        .addr        (addr),
        .data_in     (data_in),
        .read_en     (read_en),
        .write_en    (write_en),
        .clear_req   (clear_req),
`ifdef MEM_LINE_PARITY_EN
        .inject_err  (inject_err),
        .parity_err  (parity_err),
`endif
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             par;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    logic             rd_pending = 1'b0;
    logic             exp_busy = 1'b0;
    logic [WIDTH-1:0] last_dout = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge and compare against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        check("busy", busy, exp_busy);
        if (rd_pending) begin
            e = sb.pop_front();
            check("read_valid", data_valid, 1'b1);
            check("read_data", data_out, e.data);
`ifdef MEM_LINE_PARITY_EN
            check("parity_err", parity_err, e.par);
`endif
            last_dout  = e.data;
            rd_pending = 1'b0;
        end else begin
            check("no_valid", data_valid, 1'b0);
            check("data_hold", data_out, last_dout);
        end
        $display("[TB] t=%0t addr=%0d rd=%0b wr=%0b clr=%0b sel=%0b rst_n=%0b -> dout=%02h valid=%0b busy=%0b",
                 $time, addr, read_en, write_en, clear_req, line_select, reset, data_out, data_valid, busy);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        addr     = a;
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic p);
        exp_t e;
        e.data     = d;
        e.par      = p;
        addr       = a;
        read_en    = 1'b1;
        sb.push_back(e);
        rd_pending = 1'b1;
        tick();
        read_en    = 1'b0;
    endtask

    task automatic do_rw(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] old_d);
        write_en = 1'b1;
        data_in  = d;
        do_read(a, old_d, 1'b0);
        write_en = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        line_select = 1'b0;
        addr        = '0;
        data_in     = '0;
        read_en     = 1'b0;
        write_en    = 1'b0;
        clear_req   = 1'b0;
`ifdef MEM_LINE_PARITY_EN
        inject_err  = 1'b0;
`endif

        // Reset then every line reads zero
        tick();
        reset       = 1'b1;
        line_select = 1'b1;
        for (int a = 0; a < DEPTH; a++) do_read(ADDR_W'(a), 8'h00, 1'b0);

        // Basic write/read
        do_write(2'd0, 8'hB3);
        do_write(2'd3, 8'h82);
        do_read(2'd3, 8'h82, 1'b0);
        do_read(2'd0, 8'hB3, 1'b0);

        // Deselected bank ignores write and read
        line_select = 1'b0;
        addr        = 2'd0;
        data_in     = 8'hC4;
        write_en    = 1'b1;
        read_en     = 1'b1;
        tick();
        write_en    = 1'b0;
        read_en     = 1'b0;
        line_select = 1'b1;
        do_read(2'd0, 8'hB3, 1'b0);

        // Read-first on same-address read+write
        do_write(2'd1, 8'h1E);
        do_rw(2'd1, 8'hF3, 8'h1E);
        do_read(2'd1, 8'hF3, 1'b0);

        // Clear request while deselected does nothing
        line_select = 1'b0;
        clear_req   = 1'b1;
        tick();
        clear_req   = 1'b0;
        line_select = 1'b1;
        do_read(2'd3, 8'h82, 1'b0);

        // Clear sweep: clear wins over read/write, accesses during busy dropped
        do_write(2'd0, 8'hAA);
        do_write(2'd1, 8'h68);
        do_write(2'd2, 8'h44);
        do_write(2'd3, 8'h2C);
        do_read(2'd2, 8'h44, 1'b0);
        clear_req = 1'b1;
        read_en   = 1'b1;
        write_en  = 1'b1;
        addr      = 2'd1;
        data_in   = 8'h11;
        exp_busy  = 1'b1;
        tick();
        clear_req = 1'b0;
        addr      = 2'd0;
        data_in   = 8'hDD;
        tick();
        tick();
        tick();
        exp_busy  = 1'b0;
        tick();
        read_en   = 1'b0;
        write_en  = 1'b0;
        for (int a = 0; a < DEPTH; a++) do_read(ADDR_W'(a), 8'h00, 1'b0);

        // Reset asserted on the second busy cycle
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        do_read(2'd3, 8'h44, 1'b0);
        clear_req = 1'b1;
        exp_busy  = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        reset     = 1'b0;
        exp_busy  = 1'b0;
        last_dout = 8'h00;
        tick();
        reset     = 1'b1;
        for (int a = 0; a < DEPTH; a++) do_read(ADDR_W'(a), 8'h00, 1'b0);
        do_write(2'd2, 8'h77);
        do_read(2'd2, 8'h77, 1'b0);

        // Parity injection (ports only exist with the parity build)
`ifdef MEM_LINE_PARITY_EN
        inject_err = 1'b1;
        do_write(2'd2, 8'h95);
        inject_err = 1'b0;
        do_read(2'd2, 8'h95, 1'b1);
        do_write(2'd2, 8'h95);
        do_read(2'd2, 8'h95, 1'b0);
`else
        do_write(2'd2, 8'h95);
        do_read(2'd2, 8'h95, 1'b0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
